icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream consumer of instructions) and the memory controller.
- Serves one 32-bit instruction per request: 1-cycle latency on a hit, line refill from the memory controller on a miss.
- Accepts a flush from the ROB on mispredict so that stale fetches produce no instruction pulse.

---
 rtl/icache_direct_if.sv | 27 ++
 rtl/icache_direct.sv | 118 +++++++++++
 tb/tb_icache_direct.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Fetch/flush/memory-controller bundle for icache_direct.
//   slave  : cache view (drives IF_ins*, MC_req_sgn, MC_addr)
//   master : environment view (fetcher, ROB flush, memory controller)
// Handshakes: IF_pc_sgn is a level request held by the fetcher until it sees
// a one-cycle IF_ins_sgn pulse; MC_req_sgn is a level request held with a
// stable MC_addr until a cycle with MC_done=1 delivers MC_data for MC_addr.
interface icache_direct_if;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        flush;
  logic        MC_req_sgn;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;

  modport slave (
    input  IF_pc_sgn, IF_pc, flush, MC_done, MC_data,
    output IF_ins_sgn, IF_ins, MC_req_sgn, MC_addr
  );

  modport master (
    output IF_pc_sgn, IF_pc, flush, MC_done, MC_data,
    input  IF_ins_sgn, IF_ins, MC_req_sgn, MC_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
// Ports:
//   clk, rst (sync, active-low), rdy (low freezes all state)
//   bus       : icache_direct_if.slave (fetch request/response, flush,
//               memory-controller word read channel)
//   state_dbg : 0 = IDLE, 1 = REFILL
// Hits respond one cycle after the request edge; misses refill the whole
// line word by word and respond on the final fill edge unless a flush was
// seen during the refill.
module icache_direct #(
  parameter int INDEX_BITS     = 6,
  parameter int LINE_WORD_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  icache_direct_if.slave   bus,
  output logic             state_dbg
);
  localparam int OFF      = LINE_WORD_BITS + 2;
  localparam int TAG_BITS = 32 - OFF - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << LINE_WORD_BITS;
  localparam logic [LINE_WORD_BITS-1:0] LAST_WORD = LINE_WORD_BITS'(WORDS - 1);

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                       state;
  logic [LINES-1:0]             valid_q;
  logic [TAG_BITS-1:0]          tag_q  [LINES];
  logic [31:0]                  data_q [LINES*WORDS];

  logic [LINE_WORD_BITS-1:0]    cnt;
  logic [LINE_WORD_BITS-1:0]    req_word;
  logic [INDEX_BITS-1:0]        req_index;
  logic [TAG_BITS-1:0]          req_tag;
  logic                         abort;

  logic [LINE_WORD_BITS-1:0]    lk_word;
  logic [INDEX_BITS-1:0]        lk_index;
  logic [TAG_BITS-1:0]          lk_tag;
  logic                         hit;
  logic                         unused_pc_lsbs;

  assign lk_word        = bus.IF_pc[OFF-1:2];
  assign lk_index       = bus.IF_pc[OFF+INDEX_BITS-1:OFF];
  assign lk_tag         = bus.IF_pc[31:OFF+INDEX_BITS];
  assign hit            = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign unused_pc_lsbs = ^bus.IF_pc[1:0];
  assign state_dbg      = (state == REFILL);

  // Data array: only the refill path writes it, one word per MC_done.
  always_ff @(posedge clk) begin
    if (rst && rdy && state == REFILL && bus.MC_done)
      data_q[{req_index, cnt}] <= bus.MC_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      valid_q        <= '0;
      cnt            <= '0;
      req_word       <= '0;
      req_index      <= '0;
      req_tag        <= '0;
      abort          <= 1'b0;
      bus.IF_ins_sgn <= 1'b0;
      bus.IF_ins     <= '0;
      bus.MC_req_sgn <= 1'b0;
      bus.MC_addr    <= '0;
    end else if (!rdy) begin
      bus.IF_ins_sgn <= 1'b0;
    end else begin
      bus.IF_ins_sgn <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.IF_pc_sgn && !bus.flush) begin
            if (hit) begin
              bus.IF_ins_sgn <= 1'b1;
              bus.IF_ins     <= data_q[{lk_index, lk_word}];
            end else begin
              req_word       <= lk_word;
              req_index      <= lk_index;
              req_tag        <= lk_tag;
              cnt            <= '0;
              abort          <= 1'b0;
              state          <= REFILL;
              bus.MC_req_sgn <= 1'b1;
              bus.MC_addr    <= {lk_tag, lk_index, {OFF{1'b0}}};
            end
          end
        end
        REFILL: begin
          if (bus.flush) abort <= 1'b1;
          if (bus.MC_done) begin
            cnt         <= cnt + 1'b1;
            bus.MC_addr <= bus.MC_addr + 32'd4;
            if (cnt == LAST_WORD) begin
              valid_q[req_index] <= 1'b1;
              tag_q[req_index]   <= req_tag;
              bus.MC_req_sgn     <= 1'b0;
              abort              <= 1'b0;
              state              <= IDLE;
              // A flush on this very edge also suppresses the response.
              if (!abort && !bus.flush) begin
                bus.IF_ins_sgn <= 1'b1;
                // The last word is still on MC_data; earlier words are stored.
                bus.IF_ins <= (req_word == LAST_WORD) ? bus.MC_data
                                                      : data_q[{req_index, req_word}];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic state_dbg;

  icache_direct_if bus();

  icache_direct #(.INDEX_BITS(6), .LINE_WORD_BITS(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  int mem_lat = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: mem_word = 32'h11;
      32'h104: mem_word = 32'h22;
      32'h108: mem_word = 32'h33;
      32'h10C: mem_word = 32'h44;
      32'h20C: mem_word = 32'hDEAD_BEEF;
      default: mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // ---------------- memory controller model ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.MC_done = 1'b0;
    bus.MC_data = '0;
    forever begin
      @(negedge clk);
      bus.MC_done = 1'b0;
      if (rst && bus.MC_req_sgn) begin
        if (wait_cnt == mem_lat - 1) begin
          bus.MC_done = 1'b1;
          bus.MC_data = mem_word(bus.MC_addr);
          addr_log.push_back(bus.MC_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.IF_ins_sgn) begin
        if (exp_q.size() == 0) check("spurious_pulse", 32'd1, 32'd0);
        else check("ins", bus.IF_ins, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, output int cyc);
    @(negedge clk);
    bus.IF_pc_sgn = 1'b1;
    bus.IF_pc     = pc;
    exp_q.push_back(exp);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.IF_ins_sgn && cyc < LIMIT);
    if (!bus.IF_ins_sgn) check("fetch_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.IF_pc_sgn = 1'b0;
  endtask

  // Consecutive word requests to the line at base; rdy held low for 5 cycles
  // while word index gap is presented.
  task automatic stream(input logic [31:0] base, input int gap);
    logic [31:0] addr_snap;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.IF_pc_sgn = 1'b1;
      bus.IF_pc     = base + 32'(4 * i);
      exp_q.push_back(mem_word(base + 32'(4 * i)));
      if (i == gap) begin
        rdy = 1'b0;
        addr_snap = bus.MC_addr;
        repeat (5) begin
          @(posedge clk); #1;
          check("rdy_low_sgn", 32'(bus.IF_ins_sgn), 32'd0);
          check("rdy_low_addr", bus.MC_addr, addr_snap);
          @(negedge clk);
        end
        rdy = 1'b1;
      end
      @(posedge clk); #1;
      check("stream_sgn", 32'(bus.IF_ins_sgn), 32'd1);
      check("stream_req", 32'(bus.MC_req_sgn), 32'd0);
    end
    @(negedge clk);
    bus.IF_pc_sgn = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (addr_log.size() < n && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (addr_log.size() < n) check("mc_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.MC_req_sgn && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("refill_end", 32'(bus.MC_req_sgn), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [31:0] pc;
    bus.IF_pc_sgn = 1'b0;
    bus.IF_pc     = '0;
    bus.flush     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ins_sgn", 32'(bus.IF_ins_sgn), 32'd0);
    check("rst_ins", bus.IF_ins, 32'd0);
    check("rst_req", 32'(bus.MC_req_sgn), 32'd0);
    check("rst_addr", bus.MC_addr, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, requested word is not the last one.
    addr_log.delete();
    fetch(32'h104, 32'h22, cyc);
    check("cold_lat", 32'(cyc), 32'd13);
    check("cold_nwords", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("cold_addr", addr_log[i], 32'h100 + 32'(4 * i));

    // Back-to-back hits.
    stream(32'h100, -1);

    // Flush on the same edge as a hit request drops the response.
    @(negedge clk);
    bus.IF_pc_sgn = 1'b1;
    bus.IF_pc     = 32'h100;
    bus.flush     = 1'b1;
    @(posedge clk); #1;
    check("flush_idle_sgn", 32'(bus.IF_ins_sgn), 32'd0);
    @(negedge clk);
    bus.IF_pc_sgn = 1'b0;
    bus.flush     = 1'b0;

    // Last word forwarded from MC_data.
    fetch(32'h20C, 32'hDEAD_BEEF, cyc);
    check("fwd_lat", 32'(cyc), 32'd13);
    check("fwd_req_low", 32'(bus.MC_req_sgn), 32'd0);

    // Flush during the second word: no response, line still installed.
    addr_log.delete();
    @(negedge clk);
    bus.IF_pc_sgn = 1'b1;
    bus.IF_pc     = 32'h644;
    wait_log(1);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.IF_pc_sgn = 1'b0;
    @(negedge clk);
    bus.flush     = 1'b0;
    wait_idle();
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    fetch(32'h648, mem_word(32'h648), cyc);
    check("abort_then_hit_lat", 32'(cyc), 32'd1);

    // Conflict eviction on index 0x10.
    fetch(32'h500, mem_word(32'h500), cyc);
    check("conflict_miss_lat", 32'(cyc), 32'd13);
    fetch(32'h100, 32'h11, cyc);
    check("evicted_miss_lat", 32'(cyc), 32'd13);

    // rdy stall in the middle of a hit stream.
    stream(32'h100, 2);

    // Reset mid-refill invalidates everything.
    addr_log.delete();
    @(negedge clk);
    bus.IF_pc_sgn = 1'b1;
    bus.IF_pc     = 32'h300;
    exp_q.push_back(mem_word(32'h300));
    wait_log(1);
    @(negedge clk);
    rst = 1'b0;
    bus.IF_pc_sgn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_req", 32'(bus.MC_req_sgn), 32'd0);
    check("midrst_ins_sgn", 32'(bus.IF_ins_sgn), 32'd0);
    fetch(32'h100, 32'h11, cyc);
    check("post_rst_miss_lat", 32'(cyc), 32'd13);

    // Random fetches with random memory latency.
    for (int n = 0; n < 20; n++) begin
      pc = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
      mem_lat = $urandom_range(1, 4);
      fetch(pc, mem_word(pc), cyc);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
